data_mem_responder: RTL and testbench

//  Data-memory responder serving the MEM-stage initiator's load/store requests.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_store_align.sv | 38 +++
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module  : dmem_pkg
//  Brief   : Shared strobe codes, FSM states and MMIO addresses for the
//            data-memory responder.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dmem_pkg;

    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0011;
    localparam logic [3:0] SZ_W = 4'b1111;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_e;

    localparam logic [31:0] CNT_LO_ADDR = 32'hFFFF_FFF0;
    localparam logic [31:0] CNT_HI_ADDR = 32'hFFFF_FFF4;

endpackage

`default_nettype wire

// File: rtl/dmem_store_align.sv
// ============================================================================
//  Module  : dmem_store_align
//  Brief   : Converts a right-aligned store and its size code into byte-lane
//            enables and lane-positioned data; flags misalignment/bad codes.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_store_align
    import dmem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [3:0]  lanes,
    output logic [31:0] lane_data,
    output logic        misalign,
    output logic        code_err
);

    always_comb begin
        lanes     = wstrb << offset;
        lane_data = wdata << {offset, 3'b000};
        misalign  = 1'b0;
        code_err  = 1'b0;
        case (wstrb)
            4'b0000: ;
            SZ_B:    ;
            SZ_H:    misalign = offset[0];
            SZ_W:    misalign = |offset;
            default: code_err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module  : data_mem_responder
//  Brief   : MEM-stage data RAM with combinational read, byte-lane stores,
//            post-reset zero sweep and sticky error capture.
//            Optional 64-bit cycle counter MMIO under DMEM_CYCLE_CNT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int INIT_CLEAR  = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_mem_addr_i,
    input  logic [31:0] data_mem_wdata_i,
    input  logic        data_mem_we_i,
    input  logic [3:0]  data_mem_wstrb_i,
    input  logic        data_mem_re_i,
    output logic [31:0] data_mem_rdata_o,
    output logic        data_mem_ready_o,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    input  logic        err_clr_i
);

    localparam int            AW         = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH_WORDS - 1);

    dmem_state_e   r_state;
    logic [AW-1:0] r_clr_idx;
    logic          r_ready;
    logic          r_err;
    logic [31:0]   r_err_addr;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_in_range;
    logic [AW-1:0] w_word_idx;
    logic [3:0]    w_lanes;
    logic [31:0]   w_lane_data;
    logic          w_misalign;
    logic          w_code_err;
    logic          w_is_cnt;
    logic          w_wr_active;
    logic          w_wr_err;
    logic          w_wr_en;
    logic          w_rd_err;
    logic          w_err;

    assign w_in_range = (data_mem_addr_i[31:AW+2] == '0);
    assign w_word_idx = data_mem_addr_i[AW+1:2];

    dmem_store_align u_align (
        .offset    (data_mem_addr_i[1:0]),
        .wstrb     (data_mem_wstrb_i),
        .wdata     (data_mem_wdata_i),
        .lanes     (w_lanes),
        .lane_data (w_lane_data),
        .misalign  (w_misalign),
        .code_err  (w_code_err)
    );

`ifdef DMEM_CYCLE_CNT_EN
    logic [63:0] r_cnt;

    assign w_is_cnt = (data_mem_addr_i == CNT_LO_ADDR) || (data_mem_addr_i == CNT_HI_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= r_cnt + 64'd1;
    end
`else
    assign w_is_cnt = 1'b0;
`endif

    // An all-zero strobe is a no-op store and never counts as an error.
    assign w_wr_active = data_mem_we_i && r_ready && (data_mem_wstrb_i != '0) && !w_is_cnt;
    assign w_wr_err    = w_wr_active && (!w_in_range || w_misalign || w_code_err);
    assign w_wr_en     = w_wr_active && !w_wr_err;
    assign w_rd_err    = data_mem_re_i && r_ready && !w_in_range && !w_is_cnt;
    assign w_err       = w_wr_err || w_rd_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= (INIT_CLEAR != 0) ? CLEAR : READY;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == c_last_idx) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end
                end
                default: r_ready <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lanes[i]) r_mem[w_word_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
            end
        end
    end

    // A new error outranks a same-cycle clear and retakes the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err) begin
            r_err <= 1'b1;
            if (!r_err || err_clr_i) r_err_addr <= data_mem_addr_i;
        end else if (err_clr_i) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end
    end

    always_comb begin
        data_mem_rdata_o = '0;
        if (data_mem_re_i && r_ready) begin
            if (w_in_range) data_mem_rdata_o = r_mem[w_word_idx];
`ifdef DMEM_CYCLE_CNT_EN
            if (data_mem_addr_i == CNT_LO_ADDR) data_mem_rdata_o = r_cnt[31:0];
            if (data_mem_addr_i == CNT_HI_ADDR) data_mem_rdata_o = r_cnt[63:32];
`endif
        end
    end

    assign data_mem_ready_o = r_ready;
    assign err_o            = r_err;
    assign err_addr_o       = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module  : tb_data_mem_responder
//  Brief   : Self-checking bench for data_mem_responder (DEPTH_WORDS=16).
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_data_mem_responder;

    localparam int DEPTH = 16;
    localparam int BYTES = DEPTH * 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  wstrb;
    logic        re;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [31:0] err_addr;
    logic        err_clr;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .INIT_CLEAR(1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_mem_addr_i  (addr),
        .data_mem_wdata_i (wdata),
        .data_mem_we_i    (we),
        .data_mem_wstrb_i (wstrb),
        .data_mem_re_i    (re),
        .data_mem_rdata_o (rdata),
        .data_mem_ready_o (ready),
        .err_o            (err),
        .err_addr_o       (err_addr),
        .err_clr_i        (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Byte-addressed reference memory and error state.
    logic [7:0]  m_bytes [BYTES];
    logic        m_err;
    logic [31:0] m_err_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int unsigned base;
        if (a >= BYTES) return 32'h0;
        base = a & ~32'd3;
        return {m_bytes[base+3], m_bytes[base+2], m_bytes[base+1], m_bytes[base]};
    endfunction

    task automatic m_access(input logic w, input logic r, input logic c, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        int  size;
        bit  bad;
        bad = 0;
        if (w && s != 4'b0000) begin
            size = (s == 4'b0001) ? 1 : (s == 4'b0011) ? 2 : (s == 4'b1111) ? 4 : 0;
            if (size == 0 || a >= BYTES || (a % size) != 0) bad = 1;
            else for (int b = 0; b < size; b++) m_bytes[a+b] = d[8*b +: 8];
        end
        if (r && a >= BYTES) bad = 1;
        if (bad) begin
            if (!m_err || c) m_err_addr = a;
            m_err = 1'b1;
        end else if (c) begin
            m_err      = 1'b0;
            m_err_addr = 32'h0;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < BYTES; i++) m_bytes[i] = 8'h00;
        m_err      = 1'b0;
        m_err_addr = 32'h0;
    endtask

    // Called one time unit after a rising edge; returns to that phase.
    task automatic apply(input logic w, input logic r, input logic c, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic e, output logic [31:0] ea);
        we = w; re = r; err_clr = c; addr = a; wdata = d; wstrb = s;
        #4;
        rd = rdata;
        @(posedge clk);
        #1;
        e  = err;
        ea = err_addr;
        m_access(w, r, c, a, d, s);
        we = 1'b0; re = 1'b0; err_clr = 1'b0;
    endtask

    task automatic sweep_and_verify(input string tag);
        logic [31:0] rd;
        logic        e;
        logic [31:0] ea;
        for (int k = 0; k <= DEPTH; k++) begin
            check({tag, "_ready_k"}, {31'd0, ready}, {31'd0, (k == DEPTH)});
            if (k < DEPTH) begin
                @(posedge clk);
                #1;
            end
        end
        m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            apply(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, e, ea);
            check({tag, "_zero_word"}, rd, 32'h0);
        end
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic        clr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s,
                                input logic [31:0] xr, input logic xe, input logic [31:0] xa);
        vec_t v;
        v.we = w; v.re = r; v.clr = c; v.addr = a; v.wdata = d; v.wstrb = s;
        v.exp_rdata = xr; v.exp_err = xe; v.exp_eaddr = xa;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [31:0] ea;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic [3:0]  codes [5];

        tbl.push_back(mk(1, 0, 0, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0,        0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h09, 32'h00000055, 4'h1, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h08, 32'h0,        4'h0, 32'hDEAD55EF, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0A, 32'h00001234, 4'h3, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h08, 32'h0,        4'h0, 32'h123455EF, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h08, 32'hCAFEF00D, 4'hF, 32'h123455EF, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h08, 32'h0,        4'h0, 32'hCAFEF00D, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h05, 32'h0000BEEF, 4'h3, 32'h0,        1, 32'h5));
        tbl.push_back(mk(0, 1, 0, 32'h04, 32'h0,        4'h0, 32'h0,        1, 32'h5));
        tbl.push_back(mk(1, 0, 0, 32'h02, 32'h11111111, 4'hF, 32'h0,        1, 32'h5));
        tbl.push_back(mk(0, 1, 0, 32'h00, 32'h0,        4'h0, 32'h0,        1, 32'h5));
        tbl.push_back(mk(0, 0, 1, 32'h00, 32'h0,        4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h40, 32'h0,        4'h0, 32'h0,        1, 32'h40));
        tbl.push_back(mk(0, 1, 1, 32'h80, 32'h0,        4'h0, 32'h0,        1, 32'h80));
        tbl.push_back(mk(0, 0, 1, 32'h00, 32'h0,        4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h100, 32'hFFFFFFFF, 4'h0, 32'h0,       0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0C, 32'hFFFFFFFF, 4'h7, 32'h0,        1, 32'hC));
        tbl.push_back(mk(0, 0, 1, 32'h00, 32'h0,        4'h0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0F, 32'h000000AB, 4'h1, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0E, 32'h0,        4'h0, 32'hAB000000, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h40, 32'h00000001, 4'hF, 32'h0,        1, 32'h40));
        tbl.push_back(mk(0, 1, 1, 32'h0C, 32'h0,        4'h0, 32'hAB000000, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'hFFFFFFF0, 32'h0,  4'h0, 32'h0,        1, 32'hFFFFFFF0));
        tbl.push_back(mk(1, 0, 0, 32'hFFFFFFF4, 32'h7,  4'hF, 32'h0,        1, 32'hFFFFFFF0));
        tbl.push_back(mk(0, 0, 1, 32'h00, 32'h0,        4'h0, 32'h0,        0, 32'h0));

        codes[0] = 4'h0; codes[1] = 4'h1; codes[2] = 4'h3; codes[3] = 4'hF; codes[4] = 4'h0;

        rst_n = 1'b0; we = 1'b0; re = 1'b0; err_clr = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_err_addr", err_addr, 32'h0);
        rst_n = 1'b1;
        sweep_and_verify("init");

        foreach (tbl[i]) begin
            apply(tbl[i].we, tbl[i].re, tbl[i].clr, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd, e, ea);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
            check($sformatf("tbl%0d_err_addr", i), ea, tbl[i].exp_eaddr);
        end

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                7:       a = 32'(BYTES) + ($urandom_range(0, 63));
                8:       a = $urandom;
                9:       a = 32'hFFFFFFF0;
                default: a = $urandom_range(0, BYTES - 1);
            endcase
            codes[4] = 4'($urandom_range(0, 15));
            s = codes[$urandom_range(0, 4)];
            we = 1'b0;
            exp_rd = 32'h0;
            begin
                logic w, r, c;
                w = ($urandom_range(0, 1) == 1);
                r = ($urandom_range(0, 1) == 1);
                c = ($urandom_range(0, 9) == 0);
                if (r) exp_rd = m_read(a);
                apply(w, r, c, a, $urandom, s, rd, e, ea);
            end
            check("rand_rdata", rd, exp_rd);
            check("rand_err", {31'd0, e}, {31'd0, m_err});
            check("rand_err_addr", ea, m_err_addr);
        end

        // Ensure memory holds data, then interrupt the sweep at index 7.
        apply(1'b1, 1'b0, 1'b0, 32'h3C, 32'hA5A5A5A5, 4'hF, rd, e, ea);
        apply(1'b1, 1'b0, 1'b0, 32'h04, 32'h5A5A5A5A, 4'hF, rd, e, ea);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("midsweep_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        check("midsweep_reset_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        sweep_and_verify("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
